// File: rtl/sal_ref_pkg.sv
// sal_ref_pkg: shared state, mode and debt-width definitions for the SAL refresh manager
package sal_ref_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RFC} ref_state_t;
  localparam int REF_MAX_POSTPONE = 8;
  localparam int REF_DEBT_W = $clog2(REF_MAX_POSTPONE + 1);
  localparam logic REF_MODE_AB = 1'b0;
  localparam logic REF_MODE_PB = 1'b1;
  function automatic int debt_w(int max_postpone);
    return $clog2(max_postpone + 1);
  endfunction
endpackage

// File: rtl/sal_ref_interval_timer.sv
// sal_ref_interval_timer: tREFI tick generator with saturating refresh debt, urgent hint and sticky overflow
module sal_ref_interval_timer import sal_ref_pkg::*; #(
  parameter int TREFI_W = 16,
  parameter int MAX_POSTPONE = 8,
  parameter int DEBT_W = debt_w(MAX_POSTPONE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [TREFI_W-1:0] trefi,
  input  logic               done,
  output logic [DEBT_W-1:0]  debt,
  output logic               urgent,
  output logic               ovf
);
  logic [TREFI_W-1:0] cnt;
  logic [DEBT_W-1:0] debt_nxt;
  logic run, tick, sat;
  always_comb begin
    run = en && trefi != '0;
    tick = run && cnt == trefi - TREFI_W'(1);
    sat = debt == DEBT_W'(MAX_POSTPONE);
    debt_nxt = tick == done ? debt
             : tick ? (sat ? debt : debt + DEBT_W'(1))
             : (debt != '0 ? debt - DEBT_W'(1) : debt);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      debt <= '0;
      urgent <= 1'b0;
      ovf <= 1'b0;
    end else begin
      cnt <= (!run || tick) ? '0 : cnt + TREFI_W'(1);
      debt <= debt_nxt;
      urgent <= debt_nxt >= DEBT_W'(MAX_POSTPONE);
      ovf <= ovf || (tick && !done && sat);
    end
endmodule

// File: rtl/sal_ref_ctrl.sv
// sal_ref_ctrl: refresh manager driving per-bank ref_req/ref_gnt in all-bank or round-robin per-bank mode
module sal_ref_ctrl import sal_ref_pkg::*; #(
  parameter int BK_CNT = 16,
  parameter int TREFI_W = 16,
  parameter int TRFC_W = 8,
  parameter int MAX_POSTPONE = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_ref_en,
  input  logic                            cfg_per_bank,
  input  logic [TREFI_W-1:0]              cfg_trefi,
  input  logic [TRFC_W-1:0]               cfg_trfc,
  input  logic                            sched_idle_i,
  output logic [BK_CNT-1:0]               ref_req_o,
  input  logic [BK_CNT-1:0]               ref_gnt_i,
  output logic                            ref_urgent_o,
  output logic                            ref_busy_o,
  output logic [debt_w(MAX_POSTPONE)-1:0] ref_debt_o,
  output logic                            ref_ovf_o
);
  localparam int PTR_W = BK_CNT > 1 ? $clog2(BK_CNT) : 1;
  ref_state_t state, state_nxt;
  logic [BK_CNT-1:0] pend, pend_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [TRFC_W-1:0] rfc, rfc_nxt;
  logic mode, mode_nxt, start, done;
  sal_ref_interval_timer #(
    .TREFI_W(TREFI_W),
    .MAX_POSTPONE(MAX_POSTPONE)
  ) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .en(cfg_ref_en),
    .trefi(cfg_trefi),
    .done(done),
    .debt(ref_debt_o),
    .urgent(ref_urgent_o),
    .ovf(ref_ovf_o)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      pend <= '0;
      ptr <= '0;
      mode <= REF_MODE_AB;
      rfc <= '0;
    end else begin
      state <= state_nxt;
      pend <= pend_nxt;
      ptr <= ptr_nxt;
      mode <= mode_nxt;
      rfc <= rfc_nxt;
    end
  always_comb begin
    start = state == IDLE && cfg_ref_en && ref_debt_o != '0 && (sched_idle_i || ref_urgent_o);
    done = state == REQ && (pend & ~ref_gnt_i) == '0;
    state_nxt = start ? REQ
              : done ? WAIT_RFC
              : (state == WAIT_RFC && rfc <= TRFC_W'(1)) ? IDLE
              : state;
    mode_nxt = start ? cfg_per_bank : mode;
    pend_nxt = start ? (cfg_per_bank == REF_MODE_PB ? BK_CNT'(1) << ptr : '1) : pend & ~ref_gnt_i;
    ptr_nxt = (done && mode == REF_MODE_PB) ? (ptr == PTR_W'(BK_CNT - 1) ? '0 : ptr + PTR_W'(1)) : ptr;
    rfc_nxt = done ? cfg_trfc : state == WAIT_RFC ? rfc - TRFC_W'(1) : rfc;
  end
  always_comb begin
    ref_req_o = pend;
    ref_busy_o = state != IDLE;
  end
endmodule

// File: tb/tb_sal_ref_ctrl.sv
// tb_sal_ref_ctrl: vector table, directed corner sequences and random stimulus against a behavioural refresh model
module tb_sal_ref_ctrl;
  localparam int BK = 4;
  localparam int MAXP = 4;
  localparam int TW = 16;
  localparam int RW = 8;
  localparam int DW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic pb = 1'b0;
  logic idle = 1'b0;
  logic [TW-1:0] trefi = '0;
  logic [RW-1:0] trfc = '0;
  logic [BK-1:0] gnt = '0;
  logic [BK-1:0] req;
  logic urg, busy, ovf;
  logic [DW-1:0] debt;

  sal_ref_ctrl #(.BK_CNT(BK), .TREFI_W(TW), .TRFC_W(RW), .MAX_POSTPONE(MAXP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_ref_en(en),
    .cfg_per_bank(pb),
    .cfg_trefi(trefi),
    .cfg_trfc(trfc),
    .sched_idle_i(idle),
    .ref_req_o(req),
    .ref_gnt_i(gnt),
    .ref_urgent_o(urg),
    .ref_busy_o(busy),
    .ref_debt_o(debt),
    .ref_ovf_o(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 requesting, 2 waiting out tRFC
  int m_cnt, m_debt, m_phase, m_ptr, m_left;
  bit m_ovf, m_mode;
  logic [BK-1:0] m_pend;

  function automatic void m_reset();
    m_cnt = 0; m_debt = 0; m_phase = 0; m_ptr = 0; m_left = 0;
    m_ovf = 0; m_mode = 0; m_pend = '0;
  endfunction

  function automatic void m_step();
    bit run, tick, start, done;
    int d;
    run = en && trefi != 0;
    tick = run && m_cnt == int'(trefi) - 1;
    start = m_phase == 0 && en && m_debt > 0 && (idle || m_debt >= MAXP);
    done = m_phase == 1 && (m_pend & ~gnt) == '0;
    m_cnt = run ? (tick ? 0 : m_cnt + 1) : 0;
    d = m_debt + int'(tick) - int'(done);
    if (d > MAXP) begin
      d = MAXP;
      m_ovf = 1;
    end
    m_debt = d;
    if (start) begin
      m_phase = 1;
      m_mode = pb;
      m_pend = pb ? BK'(1 << m_ptr) : '1;
    end else if (m_phase == 1) begin
      m_pend = m_pend & ~gnt;
      if (done) begin
        m_phase = 2;
        m_left = trfc > 1 ? int'(trfc) : 1;
        if (m_mode) m_ptr = (m_ptr + 1) % BK;
      end
    end else if (m_phase == 2) begin
      m_left--;
      if (m_left == 0) m_phase = 0;
    end
  endfunction

  task automatic cycle();
    if (!rst_n) m_reset();
    else m_step();
    @(posedge clk);
    #1;
    chk("req", 32'(req), 32'(m_pend));
    chk("debt", 32'(debt), 32'(m_debt));
    chk("urgent", 32'(urg), 32'(m_debt >= MAXP));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  int t, age, first_one, wait_cyc;
  logic [BK-1:0] order[$];

  task automatic do_reset();
    rst_n = 1'b0;
    gnt = '0;
    cycle();
    rst_n = 1'b1;
    t = 0; age = 0; first_one = -1; wait_cyc = 0;
    order.delete();
  endtask

  // Grants every pending bank once its request has been visible for more than lat cycles
  task automatic run_auto(int n, int lat);
    for (int k = 0; k < n; k++) begin
      gnt = (m_phase == 1 && age > lat) ? m_pend : '0;
      cycle();
      t++;
      age = (m_phase == 1) ? age + 1 : 0;
      if (age == 1) order.push_back(req);
      if (busy && req == '0) wait_cyc++;
      if (first_one < 0 && debt == DW'(1)) first_one = t;
    end
    gnt = '0;
  endtask

  typedef struct {
    bit r, e, i;
    logic [BK-1:0] g, q;
    int d;
    bit u, b, o;
  } vec_t;
  vec_t tv[19];

  initial begin
    tv[0]  = '{0, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0};
    tv[1]  = '{1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0};
    tv[2]  = '{1, 1, 0, 4'h0, 4'h0, 1, 0, 0, 0};
    tv[3]  = '{1, 1, 0, 4'h0, 4'h0, 1, 0, 0, 0};
    tv[4]  = '{1, 1, 0, 4'h0, 4'h0, 2, 0, 0, 0};
    tv[5]  = '{1, 1, 1, 4'h0, 4'hF, 2, 0, 1, 0};
    tv[6]  = '{1, 1, 1, 4'h1, 4'hE, 3, 0, 1, 0};
    tv[7]  = '{1, 1, 1, 4'h8, 4'h6, 3, 0, 1, 0};
    tv[8]  = '{1, 1, 1, 4'h6, 4'h0, 3, 0, 1, 0};
    tv[9]  = '{1, 1, 1, 4'h0, 4'h0, 3, 0, 1, 0};
    tv[10] = '{1, 1, 1, 4'h0, 4'h0, 4, 1, 0, 0};
    tv[11] = '{1, 1, 0, 4'h0, 4'hF, 4, 1, 1, 0};
    tv[12] = '{1, 1, 0, 4'hF, 4'h0, 4, 1, 1, 0};
    tv[13] = '{1, 0, 0, 4'h0, 4'h0, 4, 1, 1, 0};
    tv[14] = '{1, 0, 0, 4'h0, 4'h0, 4, 1, 0, 0};
    tv[15] = '{1, 0, 1, 4'h0, 4'h0, 4, 1, 0, 0};
    tv[16] = '{1, 1, 0, 4'h0, 4'hF, 4, 1, 1, 0};
    tv[17] = '{1, 1, 0, 4'h0, 4'hF, 4, 1, 1, 1};
    tv[18] = '{0, 1, 0, 4'h6, 4'h0, 0, 0, 0, 0};
    pb = 1'b0;
    trefi = 16'd2;
    trfc = 8'd2;
    for (int k = 0; k < 19; k++) begin
      rst_n = tv[k].r;
      en = tv[k].e;
      idle = tv[k].i;
      gnt = tv[k].g;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_req", k), 32'(req), 32'(tv[k].q));
      chk($sformatf("vec%0d_debt", k), 32'(debt), 32'(tv[k].d));
      chk($sformatf("vec%0d_urgent", k), 32'(urg), 32'(tv[k].u));
      chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(tv[k].b));
      chk($sformatf("vec%0d_ovf", k), 32'(ovf), 32'(tv[k].o));
    end

    // All-bank refresh with idle scheduler
    en = 1'b1; pb = 1'b0; idle = 1'b1; trefi = 16'd100; trfc = 8'd10;
    do_reset();
    run_auto(130, 2);
    chk("ab_first_tick", 32'(first_one), 32'd100);
    chk("ab_wait_cycles", 32'(wait_cyc), 32'd10);
    chk("ab_req_count", 32'(order.size()), 32'd1);
    if (order.size() > 0) chk("ab_req_mask", 32'(order[0]), 32'hF);
    chk("ab_debt_end", 32'(debt), 32'd0);

    // Per-bank round robin wraps the pointer
    pb = 1'b1; trefi = 16'd50;
    do_reset();
    run_auto(270, 2);
    chk("pb_req_count", 32'(order.size()), 32'd5);
    for (int k = 0; k < 5 && k < order.size(); k++)
      chk($sformatf("pb_bank%0d", k), 32'(order[k]), 32'(1 << (k % BK)));

    // Busy scheduler: debt climbs to urgent, then saturates and overflows
    pb = 1'b0; idle = 1'b0; trefi = 16'd100;
    do_reset();
    run_auto(401, 1000);
    chk("urg_debt", 32'(debt), 32'd4);
    chk("urg_flag", 32'(urg), 32'd1);
    chk("urg_req", 32'(req), 32'hF);
    chk("urg_ovf_pre", 32'(ovf), 32'd0);
    run_auto(100, 1000);
    chk("sat_debt", 32'(debt), 32'd4);
    chk("sat_ovf", 32'(ovf), 32'd1);
    run_auto(30, 0);

    // Enable dropped mid-REQ: refresh completes, ticks stop, restart counts from zero
    idle = 1'b1; trefi = 16'd20;
    do_reset();
    run_auto(21, 1000);
    chk("dis_in_req", 32'(busy), 32'd1);
    en = 1'b0;
    run_auto(60, 2);
    chk("dis_debt", 32'(debt), 32'd0);
    chk("dis_busy", 32'(busy), 32'd0);
    en = 1'b1;
    run_auto(19, 2);
    chk("reen_before", 32'(debt), 32'd0);
    run_auto(1, 2);
    chk("reen_tick", 32'(debt), 32'd1);

    // Reset during REQ with a partial grant, then stray grants
    trefi = 16'd10;
    do_reset();
    run_auto(11, 1000);
    gnt = 4'b1001;
    cycle();
    chk("part_mask", 32'(req), 32'h6);
    rst_n = 1'b0;
    gnt = 4'b0110;
    cycle();
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      gnt = 4'($urandom);
      cycle();
    end
    chk("stray_req", 32'(req), 32'h0);
    chk("stray_debt", 32'(debt), 32'd0);

    // Random traffic against the model
    en = 1'b1;
    trefi = 16'd7;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom % 400 == 0) begin
        rst_n = 1'b0;
        trefi = 16'($urandom_range(0, 40));
      end else rst_n = 1'b1;
      en = ($urandom % 10) != 0;
      idle = ($urandom % 3) != 0;
      if ($urandom % 64 == 0) pb = 1'($urandom);
      trfc = 8'($urandom_range(0, 6));
      gnt = ($urandom % 3 == 0) ? 4'($urandom) : '0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
